// File: rtl/writeback_scoreboard_if.sv
// Writeback scoreboard bundle: issue, ALU/mem results,
// decode source lookup and the register-file write port.
interface writeback_scoreboard_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  issue_ready;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]      alu_data;

  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_rd;
  logic [WIDTH-1:0]      mem_data;
  logic                  mem_ready;

  logic [ADDR_WIDTH-1:0] Rs1;
  logic [ADDR_WIDTH-1:0] Rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  rs1_fwd;
  logic                  rs2_fwd;

  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] Rd;
  logic [WIDTH-1:0]      WriteData;

  modport master (
    output issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output Rs1, Rs2,
    input  issue_ready, mem_ready,
    input  rs1_busy, rs2_busy,
    input  rs1_fwd, rs2_fwd,
    input  RegWrite, Rd, WriteData
  );

  modport slave (
    input  issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  Rs1, Rs2,
    output issue_ready, mem_ready,
    output rs1_busy, rs2_busy,
    output rs1_fwd, rs2_fwd,
    output RegWrite, Rd, WriteData
  );
endinterface

// File: rtl/writeback_scoreboard.sv
// Register reservation scoreboard with ALU-priority
// result arbitration and a registered write port.
module writeback_scoreboard #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  writeback_scoreboard_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0]       r_busy;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [WIDTH-1:0]      r_wdata;

  logic                  w_issue_ready;
  logic                  w_issue_set;
  logic                  w_res_valid;
  logic [ADDR_WIDTH-1:0] w_res_rd;
  logic [WIDTH-1:0]      w_res_data;
  logic [NREG-1:0]       w_busy_nxt;
  logic                  w_fwd1;
  logic                  w_fwd2;

  assign w_issue_ready = (bus.issue_rd == '0) ||
                         !r_busy[bus.issue_rd];
  assign w_issue_set   = bus.issue_valid &&
                         w_issue_ready &&
                         (bus.issue_rd != '0);

  assign w_res_valid = bus.alu_valid || bus.mem_valid;
  assign w_res_rd    = bus.alu_valid ? bus.alu_rd
                                     : bus.mem_rd;
  assign w_res_data  = bus.alu_valid ? bus.alu_data
                                     : bus.mem_data;

  // Clear before set so a same-edge reissue keeps the bit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_res_valid && (w_res_rd != '0))
      w_busy_nxt[w_res_rd] = 1'b0;
    if (w_issue_set)
      w_busy_nxt[bus.issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_we   <= w_res_valid && (w_res_rd != '0);
      if (w_res_valid) begin
        r_rd    <= w_res_rd;
        r_wdata <= w_res_data;
      end
    end
  end

  assign w_fwd1 = r_we && (r_rd == bus.Rs1) &&
                  (bus.Rs1 != '0);
  assign w_fwd2 = r_we && (r_rd == bus.Rs2) &&
                  (bus.Rs2 != '0);

  assign bus.issue_ready = w_issue_ready;
  assign bus.mem_ready   = !bus.alu_valid;
  assign bus.rs1_fwd     = w_fwd1;
  assign bus.rs2_fwd     = w_fwd2;
  assign bus.rs1_busy    = r_busy[bus.Rs1] && !w_fwd1;
  assign bus.rs2_busy    = r_busy[bus.Rs2] && !w_fwd2;
  assign bus.RegWrite    = r_we;
  assign bus.Rd          = r_rd;
  assign bus.WriteData   = r_wdata;
endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed and random checks of writeback_scoreboard
// against a reservation-set reference model.
module tb_writeback_scoreboard;
  localparam int W = 32;
  localparam int A = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_scoreboard_if #(.WIDTH(W), .ADDR_WIDTH(A)) bus ();

  writeback_scoreboard #(.WIDTH(W), .ADDR_WIDTH(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  bit          mbusy [32];
  bit          exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_wd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    exp_we = 1'b0;
    exp_rd = '0;
    exp_wd = '0;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = '0;
    bus.mem_data    = '0;
  endtask

  function automatic bit efwd(input logic [4:0] rs);
    return exp_we && (exp_rd == rs) && (rs != 0);
  endfunction

  function automatic bit ebusy(input logic [4:0] rs);
    return (rs != 0) && mbusy[rs] && !efwd(rs);
  endfunction

  task automatic cyc();
    bit          ir;
    bit          res;
    logic [4:0]  rd;
    logic [31:0] d;
    #1;
    ir = (bus.issue_rd == 0) || !mbusy[bus.issue_rd];
    chk("issue_ready", bus.issue_ready, ir);
    chk("mem_ready", bus.mem_ready, !bus.alu_valid);
    chk("rs1_fwd", bus.rs1_fwd, efwd(bus.Rs1));
    chk("rs2_fwd", bus.rs2_fwd, efwd(bus.Rs2));
    chk("rs1_busy", bus.rs1_busy, ebusy(bus.Rs1));
    chk("rs2_busy", bus.rs2_busy, ebusy(bus.Rs2));
    @(posedge clk);
    res = 1'b1;
    rd  = '0;
    d   = '0;
    if (bus.alu_valid) begin
      rd = bus.alu_rd;
      d  = bus.alu_data;
    end else if (bus.mem_valid) begin
      rd = bus.mem_rd;
      d  = bus.mem_data;
    end else begin
      res = 1'b0;
    end
    exp_we = res && (rd != 0);
    if (res) begin
      exp_rd = rd;
      exp_wd = d;
    end
    if (res && rd != 0) mbusy[rd] = 1'b0;
    if (bus.issue_valid && ir && bus.issue_rd != 0)
      mbusy[bus.issue_rd] = 1'b1;
    #1;
    chk("RegWrite", bus.RegWrite, exp_we);
    chk("Rd", bus.Rd, exp_rd);
    chk("WriteData", bus.WriteData, exp_wd);
  endtask

  task automatic rnd_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.alu_valid   = ($urandom_range(0, 2) == 0);
      bus.alu_rd      = 5'($urandom_range(0, 7));
      bus.alu_data    = $urandom;
      bus.mem_valid   = 1'($urandom_range(0, 1));
      bus.mem_rd      = 5'($urandom_range(0, 7));
      bus.mem_data    = $urandom;
      bus.Rs1         = 5'($urandom_range(0, 7));
      bus.Rs2         = 5'($urandom_range(0, 7));
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.Rs1 = 5'd2;
    bus.Rs2 = 5'd0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd2;
    bus.alu_data  = 32'h5555_AAAA;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd2;
    #1;
    chk("rst_we", bus.RegWrite, 0);
    chk("rst_rd", bus.Rd, 0);
    chk("rst_wd", bus.WriteData, 0);
    @(posedge clk);
    #1;
    chk("rst_drop_we", bus.RegWrite, 0);
    chk("rst_drop_busy", bus.rs1_busy, 0);
    idle();
    rst = 1'b0;
    model_reset();
    cyc();

    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd5;
    bus.Rs1         = 5'd5;
    cyc();
    idle();
    #1;
    chk("r33_busy", bus.rs1_busy, 1);
    cyc();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEAD_BEEF;
    cyc();
    idle();
    #1;
    chk("r33_we", bus.RegWrite, 1);
    chk("r33_rd", bus.Rd, 5);
    chk("r33_wd", bus.WriteData, 32'hDEAD_BEEF);
    chk("r33_fwd", bus.rs1_fwd, 1);
    chk("r33_nobusy", bus.rs1_busy, 0);
    cyc();

    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'h3333_0003;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd4;
    bus.mem_data  = 32'h4444_0004;
    #1;
    chk("r34_memrdy", bus.mem_ready, 0);
    cyc();
    chk("r34_alu_rd", bus.Rd, 3);
    bus.alu_valid = 1'b0;
    cyc();
    chk("r34_mem_rd", bus.Rd, 4);
    chk("r34_mem_wd", bus.WriteData, 32'h4444_0004);
    idle();

    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    cyc();
    #1;
    chk("r35_stall", bus.issue_ready, 0);
    cyc();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 32'h7;
    cyc();
    bus.alu_valid = 1'b0;
    #1;
    chk("r35_ready", bus.issue_ready, 1);
    cyc();
    idle();

    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    bus.mem_valid   = 1'b1;
    bus.mem_rd      = 5'd9;
    bus.mem_data    = 32'h9999;
    bus.Rs1         = 5'd9;
    cyc();
    chk("r36_we", bus.RegWrite, 1);
    chk("r36_rd", bus.Rd, 9);
    idle();
    cyc();
    chk("r36_busy", bus.rs1_busy, 1);

    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'h1234;
    bus.Rs1       = 5'd0;
    cyc();
    chk("r37_we", bus.RegWrite, 0);
    chk("r37_busy", bus.rs1_busy, 0);
    chk("r37_fwd", bus.rs1_fwd, 0);
    idle();

    rnd_cycles(250);

    idle();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    for (int r = 1; r <= 4; r++) begin
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'(r);
      if (r == 4) begin
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd6;
        bus.alu_data  = 32'hCAFE_0006;
      end
      cyc();
    end
    idle();
    bus.Rs1 = 5'd1;
    bus.Rs2 = 5'd4;
    #1;
    chk("r38_pre_busy", bus.rs1_busy, 1);
    chk("r38_pre_we", bus.RegWrite, 1);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd2;
    bus.alu_data  = 32'hBAD0_0002;
    #1;
    rst = 1'b1;
    #1;
    chk("r38_we", bus.RegWrite, 0);
    chk("r38_rd", bus.Rd, 0);
    chk("r38_wd", bus.WriteData, 0);
    chk("r38_busy1", bus.rs1_busy, 0);
    chk("r38_busy4", bus.rs2_busy, 0);
    @(posedge clk);
    #2;
    idle();
    rst = 1'b0;
    model_reset();
    cyc();
    chk("r32_nowrite", bus.RegWrite, 0);

    rnd_cycles(120);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
